nibble_deserializer: RTL and testbench
======================================

Name: nibble_deserializer

Overview:
Serial-to-parallel front end for the 4-input function stage. Collects a serial bit stream into 4-bit nibbles and presents each nibble as x with a valid/ready handshake. Tracks framing via an explicit sync input, flags dropped nibbles on overrun, and counts delivered nibbles. Sits directly upstream of the function stage, which consumes x.

Parameters:
MSB_FIRST, 1, 1: first accepted bit lands in x[3]; 0: first bit lands in x[0]
CNT_W, 8, width of delivered-nibble counter

Ports:
clk  input  1  rising-edge clock
aresetn  input  1  asynchronous active-low reset
bit_in  input  1  serial data bit
bit_valid  input  1  bit_in is sampled this cycle
sync  input  1  frame marker; restarts nibble assembly
x  output  4  assembled nibble to the function stage
x_valid  output  1  x holds an undelivered nibble
x_ready  input  1  downstream accepts x this cycle
overrun  output  1  one-cycle pulse: completed nibble dropped
nib_count  output  CNT_W  number of nibbles handed over (x_valid && x_ready), wraps

Behaviour:
- One clock (clk); reset asynchronous, active-low (aresetn). Reset clears all state immediately: x=4'h0, x_valid=0, overrun=0, nib_count=0, bit index=0, shift register=0.
- Assembly FSM: COLLECT with bit index idx 0..3 (idx=0 equivalent to IDLE). Every cycle with bit_valid=1 shifts bit_in in and increments idx. MSB_FIRST=1: shreg <= {shreg[2:0], bit_in}. MSB_FIRST=0: shreg <= {bit_in, shreg[3:1]}.
- Completion: the bit accepted at idx=3 completes the nibble; idx returns to 0. The nibble goes straight into the output register on that same edge (no extra stage). x_valid rises the cycle after the 4th bit is sampled, so latency is 1 cycle from the last bit.
- sync=1 with bit_valid=1: any partial nibble is discarded; bit_in is taken as bit 0 of a new nibble, so idx becomes 1. sync=1 with bit_valid=0: idx <= 0 and the partial nibble is discarded. sync never affects the output register.
- Output register rules:
  - Held stable while x_valid=1 and x_ready=0.
  - Handshake occurs when x_valid && x_ready. On that edge x_valid clears unless a nibble completes the same cycle, in which case x loads the new nibble and x_valid stays 1 (back-to-back, no bubble).
  - A nibble that completes while x_valid=1 and x_ready=0 is dropped. x is unchanged and overrun=1 for exactly the next cycle. The assembler continues normally.
- nib_count increments by 1 on every handshake edge and wraps from 2^CNT_W-1 to 0.
- x_ready is ignored while x_valid=0.
- Reset asserted mid-nibble or with x_valid=1 loses all data. The first bit after reset release is bit 0.
- Max throughput: one nibble per 4 cycles.

Decomposition:
- Shared package nibble_pkg: localparam NIBBLE_W=4; typedef logic [NIBBLE_W-1:0] nibble_t; typedef logic [1:0] bit_idx_t.
- Sub-module nib_out_reg: single-entry holding register with valid/ready. Handles load, hold, drop and the overrun pulse.
- Assembler FSM and counter live in the top module.

Test Plan:
- Reset, then MSB_FIRST=1: drive bits 1,0,1,1 on 4 consecutive cycles with x_ready=1 -> next cycle x=4'hB, x_valid=1. x_valid drops after 1 cycle; nib_count=1.
- MSB_FIRST=0 build: bits 1,0,1,1 -> x=4'hD.
- Continuous stream 0,0,0,1, 1,1,1,0 with x_ready=1 -> x=4'h1, then x=4'hE. No overrun; nib_count=2.
- Hold x_ready=0, send 8 bits (4'h6, then 4'h9) -> x stays 4'h6 and overrun pulses 1 cycle after the 8th bit. Raise x_ready -> 4'h6 is delivered, x_valid clears, nib_count=1.
- Bits 1,1 then sync with bit 0, then bits 1,0,1 -> x=4'h5; the partial 2'b11 is discarded.
- Assert aresetn=0 asynchronously while x_valid=1 and x=4'hC -> x_valid=0 and x=4'h0 immediately. Preset nib_count to 255 (CNT_W=8), one handshake -> nib_count wraps to 0.

Source files
------------

// File: rtl/nibble_pkg.sv
// ============================================================================
// Module : nibble_pkg
// Shared types for the nibble deserializer and its output holding register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package nibble_pkg;
   localparam int NIBBLE_W = 4;

   typedef logic [NIBBLE_W-1:0] nibble_t;
   typedef logic [1:0]          bit_idx_t;

   // Assembly state is the index of the next bit to be accepted; S_IDX0 doubles as idle.
   typedef enum bit_idx_t {
      S_IDX0 = 2'd0,
      S_IDX1 = 2'd1,
      S_IDX2 = 2'd2,
      S_IDX3 = 2'd3
   } asm_state_e;
endpackage

`default_nettype wire

// File: rtl/nib_out_reg.sv
// ============================================================================
// Module : nib_out_reg
// Single-entry valid/ready holding register; drops nibbles that arrive while full.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module nib_out_reg
   import nibble_pkg::*;
(
   input  logic    clk,
   input  logic    aresetn,
   input  logic    i_load,
   input  nibble_t i_data,
   input  logic    i_ready,
   output nibble_t o_data,
   output logic    o_valid,
   output logic    o_overrun,
   output logic    o_xfer
);

   nibble_t r_data;
   logic    r_valid;
   logic    r_overrun;
   logic    w_xfer;

   assign w_xfer = r_valid && i_ready;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         // A full register that is not being drained this cycle cannot take a new nibble.
         r_overrun <= i_load && r_valid && !i_ready;
         if (i_load && (!r_valid || i_ready)) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
         end else if (w_xfer) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_data    = r_data;
   assign o_valid   = r_valid;
   assign o_overrun = r_overrun;
   assign o_xfer    = w_xfer;

endmodule

`default_nettype wire

// File: rtl/nibble_deserializer.sv
// ============================================================================
// Module : nibble_deserializer
// Serial bit stream to 4-bit nibble converter with sync framing and delivery count.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module nibble_deserializer
   import nibble_pkg::*;
#(
   parameter int MSB_FIRST = 1,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             aresetn,
   input  logic             bit_in,
   input  logic             bit_valid,
   input  logic             sync,
   output logic [3:0]       x,
   output logic             x_valid,
   input  logic             x_ready,
   output logic             overrun,
   output logic [CNT_W-1:0] nib_count
);

   asm_state_e       r_state;
   asm_state_e       w_state_nxt;
   nibble_t          r_shreg;
   nibble_t          w_shreg_nxt;
   nibble_t          w_shifted;
   nibble_t          w_fresh;
   logic             w_complete;
   logic             w_xfer;
   logic [CNT_W-1:0] r_count;

   // w_fresh is the register image after a sync restart, with bit_in as bit 0.
   generate
      if (MSB_FIRST != 0) begin : g_msb_first
         assign w_shifted = {r_shreg[2:0], bit_in};
         assign w_fresh   = {3'b000, bit_in};
      end else begin : g_lsb_first
         assign w_shifted = {bit_in, r_shreg[3:1]};
         assign w_fresh   = {bit_in, 3'b000};
      end
   endgenerate

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= S_IDX0;
         r_shreg <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_shreg <= w_shreg_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_shreg_nxt = r_shreg;
      w_complete  = 1'b0;
      if (sync) begin
         w_shreg_nxt = bit_valid ? w_fresh : '0;
         w_state_nxt = bit_valid ? S_IDX1 : S_IDX0;
      end else if (bit_valid) begin
         w_shreg_nxt = w_shifted;
         case (r_state)
            S_IDX0:  w_state_nxt = S_IDX1;
            S_IDX1:  w_state_nxt = S_IDX2;
            S_IDX2:  w_state_nxt = S_IDX3;
            default: begin
               w_state_nxt = S_IDX0;
               w_complete  = 1'b1;
            end
         endcase
      end
   end

   // The completed nibble is taken from the shift path so it lands in x on the same edge.
   nib_out_reg u_out (
      .clk       (clk),
      .aresetn   (aresetn),
      .i_load    (w_complete),
      .i_data    (w_shifted),
      .i_ready   (x_ready),
      .o_data    (x),
      .o_valid   (x_valid),
      .o_overrun (overrun),
      .o_xfer    (w_xfer)
   );

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_count <= '0;
      end else if (w_xfer) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign nib_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_nibble_deserializer.sv
// ============================================================================
// Module : tb_nibble_deserializer
// Bench for nibble_deserializer, MSB-first and LSB-first builds side by side.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_nibble_deserializer;

   logic       clk = 1'b0;
   logic       aresetn;
   logic       bit_in, bit_valid, sync, x_ready;
   logic [3:0] x1, x0;
   logic       v1, v0, ov1, ov0;
   logic [7:0] c1, c0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   nibble_deserializer #(.MSB_FIRST(1), .CNT_W(8)) dut_msb (
      .clk(clk), .aresetn(aresetn), .bit_in(bit_in), .bit_valid(bit_valid), .sync(sync),
      .x(x1), .x_valid(v1), .x_ready(x_ready), .overrun(ov1), .nib_count(c1));

   nibble_deserializer #(.MSB_FIRST(0), .CNT_W(8)) dut_lsb (
      .clk(clk), .aresetn(aresetn), .bit_in(bit_in), .bit_valid(bit_valid), .sync(sync),
      .x(x0), .x_valid(v0), .x_ready(x_ready), .overrun(ov0), .nib_count(c0));

   // Reference model: a list of bits received since the frame start, composed into a nibble once four are present.
   bit         m_b[4];
   int         m_n;
   logic       m_valid, m_ovr;
   logic [3:0] m_x1, m_x0;
   logic [7:0] m_cnt;

   always @(posedge clk or negedge aresetn) begin : model
      bit         b[4];
      int         n;
      logic       cpl, hs;
      logic [3:0] n1, n0;
      if (!aresetn) begin
         m_n <= 0; m_valid <= 1'b0; m_ovr <= 1'b0;
         m_x1 <= 4'h0; m_x0 <= 4'h0; m_cnt <= 8'd0;
         for (int i = 0; i < 4; i++) m_b[i] <= 1'b0;
      end else begin
         b = m_b; n = m_n; cpl = 1'b0;
         if (sync) begin
            n = 0;
            if (bit_valid) begin b[0] = bit_in; n = 1; end
         end else if (bit_valid) begin
            b[n] = bit_in;
            n++;
            if (n == 4) begin cpl = 1'b1; n = 0; end
         end
         for (int i = 0; i < 4; i++) begin
            n1[3-i] = b[i];
            n0[i]   = b[i];
         end
         hs = m_valid && x_ready;
         m_b <= b;
         m_n <= n;
         m_ovr <= cpl && m_valid && !x_ready;
         if (hs) m_cnt <= m_cnt + 8'd1;
         if (cpl && (!m_valid || x_ready)) begin
            m_valid <= 1'b1; m_x1 <= n1; m_x0 <= n0;
         end else if (hs) begin
            m_valid <= 1'b0;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("cyc_x_msb",  x1,  m_x1);
      chk("cyc_x_lsb",  x0,  m_x0);
      chk("cyc_v_msb",  v1,  m_valid);
      chk("cyc_v_lsb",  v0,  m_valid);
      chk("cyc_ov_msb", ov1, m_ovr);
      chk("cyc_ov_lsb", ov0, m_ovr);
      chk("cyc_c_msb",  c1,  m_cnt);
      chk("cyc_c_lsb",  c0,  m_cnt);
   end

   task automatic step(input logic v, input logic b, input logic s, input logic r);
      bit_valid = v; bit_in = b; sync = s; x_ready = r;
      @(negedge clk);
   endtask

   // Bits go out in arrival order nib[3], nib[2], nib[1], nib[0].
   task automatic send4(input logic [3:0] nib, input logic r);
      for (int i = 3; i >= 0; i--) step(1'b1, nib[i], 1'b0, r);
   endtask

   task automatic do_reset;
      bit_valid = 1'b0; bit_in = 1'b0; sync = 1'b0; x_ready = 1'b0;
      aresetn = 1'b0;
      @(negedge clk);
      aresetn = 1'b1;
   endtask

   initial begin
      aresetn = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; sync = 1'b0; x_ready = 1'b0;
      repeat (2) @(negedge clk);
      aresetn = 1'b1;
      chk("rst_x",   x1, 4'h0);
      chk("rst_v",   v1, 1'b0);
      chk("rst_cnt", c1, 8'd0);

      // 1,0,1,1 with ready high
      send4(4'b1011, 1'b1);
      chk("t1_x_msb", x1, 4'hB);
      chk("t1_x_lsb", x0, 4'hD);
      chk("t1_v",     v1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t1_v_drop", v1, 1'b0);
      chk("t1_cnt",    c1, 8'd1);

      // continuous stream, back-to-back delivery
      do_reset();
      send4(4'b0001, 1'b1);
      chk("t2_x_a", x1, 4'h1);
      send4(4'b1110, 1'b1);
      chk("t2_x_b", x1, 4'hE);
      chk("t2_ov",  ov1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t2_cnt", c1, 8'd2);

      // overrun while downstream stalls
      do_reset();
      send4(4'b0110, 1'b0);
      send4(4'b1001, 1'b0);
      chk("t3_ov",  ov1, 1'b1);
      chk("t3_x",   x1, 4'h6);
      chk("t3_xl",  x0, 4'h6);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t3_ov_end", ov1, 1'b0);
      chk("t3_v",      v1, 1'b0);
      chk("t3_cnt",    c1, 8'd1);

      // sync with a bit restarts framing
      do_reset();
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      chk("t4_x_msb", x1, 4'h5);
      chk("t4_x_lsb", x0, 4'hA);

      // sync without a bit clears the partial nibble
      do_reset();
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      send4(4'b1100, 1'b1);
      chk("t5_x_msb", x1, 4'hC);
      chk("t5_x_lsb", x0, 4'h3);

      // asynchronous reset mid-cycle while holding a nibble
      do_reset();
      send4(4'b1100, 1'b0);
      chk("t6_pre_x", x1, 4'hC);
      #2 aresetn = 1'b0;
      #1;
      chk("t6_async_x", x1, 4'h0);
      chk("t6_async_v", v1, 1'b0);
      @(negedge clk);
      aresetn = 1'b1;

      // counter wrap after 256 handshakes
      for (int i = 0; i < 255; i++) send4(4'(i), 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t7_cnt255", c1, 8'd255);
      send4(4'h7, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t7_wrap", c1, 8'd0);
      chk("t7_wrap_lsb", c0, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
